// File: rtl/seq_signed_divider_if.sv
// Start/busy handshake bundle for the sequential signed divider.
// start is sampled only while busy=0; done pulses for one cycle once busy has dropped.
`timescale 1ns/1ps
interface seq_signed_divider_if #(parameter int N = 4);
    logic [2*N-1:0] dividend;
    logic [N-1:0]   divisor;
    logic           start;
    logic [N-1:0]   quotient;
    logic [N-1:0]   remainder;
    logic           busy;
    logic           done;
    logic           overflow;
    logic           div_by_zero;

    modport master (
        output dividend, divisor, start,
        input  quotient, remainder, busy, done, overflow, div_by_zero
    );

    modport slave (
        input  dividend, divisor, start,
        output quotient, remainder, busy, done, overflow, div_by_zero
    );
endinterface

// File: rtl/seq_signed_divider.sv
// Restoring signed divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Works on magnitudes and applies the signs in the DONE state.
`timescale 1ns/1ps
module seq_signed_divider #(
    parameter int N = 4
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    seq_signed_divider_if.slave  bus,
    output logic [1:0]           o_state
);
    localparam int CW = (2 * N > 1) ? $clog2(2 * N) : 1;
    localparam logic [CW-1:0]    COUNT_LOAD = CW'(2 * N - 1);
    localparam logic [2*N-1:0]   POS_LIMIT  = (2 * N)'(2 ** (N - 1) - 1);
    localparam logic [2*N-1:0]   NEG_LIMIT  = (2 * N)'(2 ** (N - 1));

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CW-1:0]    r_count;
    logic [2*N-1:0]   r_quo;
    logic [N-1:0]     r_rem;
    logic [N-1:0]     r_dvs;
    logic             r_sign_a;
    logic             r_sign_b;
    logic [N-1:0]     r_quotient;
    logic [N-1:0]     r_remainder;
    logic             r_overflow;
    logic             r_dbz;
    logic             r_done;

    logic [2*N-1:0]   w_dvd_mag;
    logic [N-1:0]     w_dvs_mag;
    logic [N:0]       w_shift;
    logic [N:0]       w_trial;
    logic             w_qneg;
    logic             w_ovf;
    logic [N-1:0]     w_quot_fix;
    logic [N-1:0]     w_rem_fix;
    logic             w_busy;

    // Unsigned magnitudes: -2^(2N-1) maps onto 2^(2N-1), which fits unsigned in 2N bits.
    always_comb begin
        w_dvd_mag = bus.dividend[2*N-1] ? -bus.dividend : bus.dividend;
        w_dvs_mag = bus.divisor[N-1] ? -bus.divisor : bus.divisor;
    end

    // The partial remainder is always below |divisor| <= 2^(N-1), so N bits hold it.
    always_comb begin
        w_shift = {r_rem, r_quo[2*N-1]};
        w_trial = w_shift - {1'b0, r_dvs};
    end

    always_comb begin
        w_qneg     = (r_sign_a ^ r_sign_b) && (r_quo != '0);
        w_ovf      = w_qneg ? (r_quo > NEG_LIMIT) : (r_quo > POS_LIMIT);
        w_quot_fix = w_qneg ? -r_quo[N-1:0] : r_quo[N-1:0];
        w_rem_fix  = r_sign_a ? -r_rem : r_rem;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next_state = S_DIV;
            S_DIV:   if (r_count == '0) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy  = (r_state == S_DIV) || (r_state == S_DONE);
        o_state = r_state;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_count     <= '0;
            r_quo       <= '0;
            r_rem       <= '0;
            r_dvs       <= '0;
            r_sign_a    <= 1'b0;
            r_sign_b    <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_overflow  <= 1'b0;
            r_dbz       <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_quo    <= w_dvd_mag;
                        r_rem    <= '0;
                        r_dvs    <= w_dvs_mag;
                        r_sign_a <= bus.dividend[2*N-1];
                        r_sign_b <= bus.divisor[N-1];
                        r_count  <= COUNT_LOAD;
                    end
                end
                S_DIV: begin
                    if (!w_trial[N]) begin
                        r_rem <= w_trial[N-1:0];
                        r_quo <= {r_quo[2*N-2:0], 1'b1};
                    end else begin
                        r_rem <= w_shift[N-1:0];
                        r_quo <= {r_quo[2*N-2:0], 1'b0};
                    end
                    r_count <= r_count - 1'b1;
                end
                S_DONE: begin
                    r_done <= 1'b1;
                    if (r_dvs == '0) begin
                        r_quotient  <= '0;
                        r_remainder <= '0;
                        r_overflow  <= 1'b0;
                        r_dbz       <= 1'b1;
                    end else begin
                        r_quotient  <= w_quot_fix;
                        r_remainder <= w_rem_fix;
                        r_overflow  <= w_ovf;
                        r_dbz       <= 1'b0;
                    end
                end
                default: r_done <= 1'b0;
            endcase
        end
    end

    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.overflow    = r_overflow;
    assign bus.div_by_zero = r_dbz;
    assign bus.done        = r_done;
    assign bus.busy        = w_busy;
endmodule

// File: tb/tb_seq_signed_divider.sv
// Directed and random bench for seq_signed_divider (N=4) with an expected-result queue.
`timescale 1ns/1ps
module tb_seq_signed_divider;
    localparam int N = 4;
    localparam int W = 2 * N + 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] state;
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [W-1:0] exp_q[$];

    seq_signed_divider_if #(.N(N)) bus ();

    seq_signed_divider #(.N(N)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus),
        .o_state (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: SV integer division truncates toward zero, remainder follows dividend.
    function automatic logic [W-1:0] model(input int a, input int b);
        int q;
        int r;
        logic ov;
        if (b == 0) return {4'h0, 4'h0, 1'b0, 1'b1};
        q  = a / b;
        r  = a % b;
        ov = (q > 7) || (q < -8);
        return {q[3:0], r[3:0], ov, 1'b0};
    endfunction

    task automatic start_op(input int a, input int b);
        bus.dividend = 8'(a);
        bus.divisor  = 4'(b);
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start    = 1'b0;
        exp_q.push_back(model(a, b));
    endtask

    task automatic wait_result(input string tag, input int exp_lat);
        int c = 0;
        int b = 0;
        logic overlap = 1'b0;
        logic [W-1:0] obs;
        if (bus.busy) b++;
        while (!bus.done && c < 40) begin
            @(posedge clk); #1;
            c++;
            if (bus.busy) b++;
            if (bus.busy && bus.done) overlap = 1'b1;
        end
        check({tag, "_latency"}, c, exp_lat);
        check({tag, "_busy_cycles"}, b, exp_lat);
        check({tag, "_done_busy_overlap"}, {31'd0, overlap}, 32'd0);
        obs = {bus.quotient, bus.remainder, bus.overflow, bus.div_by_zero};
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            check({tag, "_result"}, obs, exp_q.pop_front());
        end
    endtask

    initial begin
        int da[6] = '{-23, 23, -56, 64, -128, 37};
        int db[6] = '{4, -4, 7, 2, -1, 0};
        int extra;
        int ra;
        int rb;

        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {bus.quotient, bus.remainder, bus.overflow, bus.div_by_zero}, 32'd0);
        check("reset_busy_done", {bus.busy, bus.done}, 32'd0);
        check("reset_state", state, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        start_op(20, -5);
        wait_result("mul_inverse", 9);
        check("mul_inverse_quotient", bus.quotient, 4'b1100);
        @(posedge clk); #1;
        check("done_pulse_width", bus.done, 32'd0);
        check("idle_after_done", bus.busy, 32'd0);

        for (int i = 0; i < 6; i++) begin
            start_op(da[i], db[i]);
            wait_result($sformatf("directed_%0d", i), 9);
            @(posedge clk); #1;
        end

        // Start re-asserted with different operands while the first op is in flight.
        start_op(-23, 4);
        repeat (3) begin
            bus.start    = 1'b1;
            bus.dividend = 8'd100;
            bus.divisor  = 4'd3;
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        wait_result("midop", 6);
        extra = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (bus.done) extra++;
        end
        check("midop_extra_done", extra, 32'd0);

        start_op(50, 7);
        wait_result("b2b_first", 9);
        start_op(-90, -6);
        wait_result("b2b_second", 9);
        @(posedge clk); #1;

        start_op(20, -5);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midreset_busy_done", {bus.busy, bus.done}, 32'd0);
        check("midreset_outputs", {bus.quotient, bus.remainder, bus.overflow, bus.div_by_zero}, 32'd0);
        check("midreset_state", state, 32'd0);
        void'(exp_q.pop_back());
        rst = 1'b0;
        start_op(20, -5);
        wait_result("after_reset", 9);
        @(posedge clk); #1;

        repeat (8) begin
            ra = int'($urandom_range(0, 255)) - 128;
            rb = int'($urandom_range(0, 15)) - 8;
            start_op(ra, rb);
            wait_result($sformatf("rand_%0d_%0d", ra, rb), 9);
            @(posedge clk); #1;
        end

        check("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/seq_signed_divider.md
# seq_signed_divider

Sequential signed two's-complement divider. It is the inverse of the Booth multiplier: it takes a 2N-bit dividend (a product-width word) and an N-bit divisor, and returns an N-bit quotient and an N-bit remainder. It uses the same start/busy handshake as the multiplier, so the two can share control logic and a common bench. Division is restoring, one quotient bit per clock, on magnitudes, with the sign applied at the end.

## Interface
- N, default 4: operand width; dividend is 2N bits, divisor/quotient/remainder are N bits.

- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- dividend  input  2N  signed dividend; sampled only on an accepted start.
- divisor  input  N  signed divisor; sampled only on an accepted start.
- start  input  1  request; accepted only in IDLE.
- quotient  output  N  signed quotient, truncated toward zero.
- remainder  output  N  signed remainder; sign follows the dividend.
- busy  output  1  high while an operation is in flight (DIV and DONE states).
- done  output  1  one-cycle pulse when results update.
- overflow  output  1  true quotient is outside [-2^(N-1), 2^(N-1)-1].
- div_by_zero  output  1  divisor was 0.

## Operation
- **States:**
  - IDLE: start=1 latches operands, goes to DIV, and loads count=2N-1.
  - DIV: one restoring step per cycle, then count decrements. At count=0 the block goes to DONE.
  - DONE: sign fix-up, registers outputs, raises done, returns to IDLE.
- **Datapath:**
  - Latch |dividend| (2N bits) and |divisor| (N bits, zero-extended to N+1), plus the sign bits.
  - Each step: shift the partial remainder/quotient pair left by 1; trial subtract |divisor|; if the result is non-negative, keep it and set quotient bit 1, else restore and set 0.
  - After 2N steps this yields a 2N-bit magnitude quotient Qm and an N-bit magnitude remainder Rm.
- **Sign rules:**
  - Quotient is negative iff the dividend and divisor signs differ and Qm is not 0.
  - Remainder takes the dividend's sign.
  - Magnitude -2^(2N-1) (most negative dividend) must be handled: compute the magnitude in 2N+1 bits, or treat it as unsigned 2^(2N-1).
- **overflow:**
  - Set if the quotient is positive and Qm > 2^(N-1)-1, or negative and Qm > 2^(N-1).
  - quotient output is then the low N bits of the signed true quotient; remainder is still correct.
- **div_by_zero:**
  - Same latency as a normal operation.
  - In DONE: quotient=0, remainder=0, overflow=0, div_by_zero=1.
- **Output holding:** quotient, remainder, overflow and div_by_zero hold until the next DONE. All are cleared on reset.
- **start while busy:** ignored, with no effect on the in-flight operation or its operands.
- **Operand changes:** dividend and divisor changing after acceptance have no effect.

## Timing
- **Reset values:** busy=0, done=0, quotient=0, remainder=0, overflow=0, div_by_zero=0; state=IDLE.
- **Reset mid-operation:** aborts at that edge, all outputs return to reset values, next start is accepted the following cycle.
- **Start-to-done timing:** if start is sampled high at edge k in IDLE:
  - busy=1 after edge k.
  - DIV occupies edges k+1 through k+2N.
  - DONE is entered after edge k+2N; done=1 and results are valid after edge k+2N+1.
  - busy=0 after edge k+2N+1.
- **Latency:** fixed at 2N+1 cycles, independent of operand values (N=4: 9 cycles).
- **Back-to-back:** start high in the cycle done is high is accepted, because the state is IDLE. Throughput is one operation per 2N+2 cycles minimum.
- **Pulse rules:** done is never high while busy is high. done lasts exactly one cycle.

## Test plan
All cases N=4.

- **Multiplier inverse:** dividend=8'b00010100 (20), divisor=4'b1011 (-5), start for 1 cycle -> after 9 cycles: done pulse, quotient=4'b1100 (-4), remainder=0, flags 0. busy high exactly 9 cycles.
- **Signed truncation:**
  - -23 / 4 -> quotient=4'b1011 (-5), remainder=4'b1101 (-3).
  - 23 / -4 -> quotient=-5, remainder=+3.
- **Range edges:**
  - -56 / 7 -> quotient=4'b1000 (-8), overflow=0.
  - 64 / 2 -> overflow=1, quotient=4'b0000.
  - -128 / -1 -> overflow=1, quotient=4'b0000, remainder=0.
- **Divide by zero:** 37 / 0 -> after 9 cycles: div_by_zero=1, quotient=0, remainder=0, overflow=0.
- **Handshake:**
  - start re-asserted and operands changed mid-operation -> result still reflects the first operands, and there is no extra done pulse.
  - start in the done cycle -> second result arrives 9 cycles later.
- **Reset mid-operation:** reset at cycle 4 of DIV -> next edge: busy=0, all outputs 0, no done pulse. A fresh 20 / -5 then completes normally.
